// File: rtl/iterative_alu.sv
// Execution-stage ALU: single-cycle logic/arith/compare, iterative shifter (SHIFT_STEP bits/cycle).
// Optional IllegalOp flag output enabled by defining ALU_ILLEGAL_OP_EN.
module iterative_alu #(
   parameter int DATA_WIDTH = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ALUResult,
`ifdef ALU_ILLEGAL_OP_EN
   output logic                  Cond,
   output logic                  IllegalOp
`else
   output logic                  Cond
`endif
);

   localparam int SHW = $clog2(DATA_WIDTH);
   localparam int CW  = SHW + 1;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_SLL = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b0111;
   localparam logic [3:0] OP_EQ  = 4'b1000;
   localparam logic [3:0] OP_NE  = 4'b1010;
   localparam logic [3:0] OP_SLT = 4'b1100;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t                state_r;
   state_t                state_nx_s;
   logic                  accept_s;
   logic                  is_shift_s;
   logic                  start_shift_s;
   logic [SHW-1:0]        shamt_s;
   logic                  slt_s;
   logic [DATA_WIDTH-1:0] alu_result_s;
   logic                  alu_cond_s;
   logic [1:0]            shift_op_r;
   logic [DATA_WIDTH-1:0] work_r;
   logic [DATA_WIDTH-1:0] work_nx_s;
   logic [SHW-1:0]        remaining_r;
   logic [SHW-1:0]        remaining_nx_s;
   logic [CW-1:0]         step_s;
   logic                  shift_last_s;
   logic [DATA_WIDTH-1:0] result_r;
   logic                  cond_r;
   logic                  out_valid_r;
`ifdef ALU_ILLEGAL_OP_EN
   logic                  alu_illegal_s;
   logic                  illegal_r;
`endif

   // DONE can hand off and accept in the same cycle, so out_ready feeds in_ready directly.
   assign in_ready      = (state_r == IDLE) || ((state_r == DONE) && out_ready);
   assign accept_s      = in_valid && in_ready;
   assign shamt_s       = SrcB[SHW-1:0];
   assign is_shift_s    = (Operation == OP_SRL) || (Operation == OP_SLL) || (Operation == OP_SRA);
   assign start_shift_s = is_shift_s && (shamt_s != '0);
   assign slt_s         = $signed(SrcA) < $signed(SrcB);

   assign ALUResult = result_r;
   assign Cond      = cond_r;
   assign out_valid = out_valid_r;
`ifdef ALU_ILLEGAL_OP_EN
   assign IllegalOp = illegal_r;
`endif

   // Single-cycle operation decode; shift codes yield SrcA for the zero-shift case.
   always_comb begin
      alu_result_s = '0;
      alu_cond_s   = 1'b0;
`ifdef ALU_ILLEGAL_OP_EN
      alu_illegal_s = 1'b0;
`endif
      case (Operation)
         OP_AND: alu_result_s = SrcA & SrcB;
         OP_OR:  alu_result_s = SrcA | SrcB;
         OP_ADD: alu_result_s = SrcA + SrcB;
         OP_SUB: alu_result_s = SrcA - SrcB;
         OP_XOR: alu_result_s = SrcA ^ SrcB;
         OP_SRL, OP_SLL, OP_SRA: alu_result_s = SrcA;
         OP_EQ: begin
            alu_result_s = SrcA - SrcB;
            alu_cond_s   = (SrcA == SrcB);
         end
         OP_NE: begin
            alu_result_s = SrcB;
            alu_cond_s   = (SrcA != SrcB);
         end
         OP_SLT: begin
            alu_result_s = {{(DATA_WIDTH-1){1'b0}}, slt_s};
            alu_cond_s   = slt_s;
         end
         default: begin
            alu_result_s = '0;
`ifdef ALU_ILLEGAL_OP_EN
            alu_illegal_s = 1'b1;
`endif
         end
      endcase
   end

   // One shift iteration: step is min(SHIFT_STEP, remaining).
   always_comb begin
      if ({1'b0, remaining_r} < CW'(SHIFT_STEP)) begin
         step_s = {1'b0, remaining_r};
      end else begin
         step_s = CW'(SHIFT_STEP);
      end
      case (shift_op_r)
         2'b10:   work_nx_s = work_r << step_s;
         2'b11:   work_nx_s = $unsigned($signed(work_r) >>> step_s);
         default: work_nx_s = work_r >> step_s;
      endcase
      remaining_nx_s = remaining_r - step_s[SHW-1:0];
      shift_last_s   = (remaining_nx_s == '0);
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nx_s = start_shift_s ? SHIFT : DONE;
            end else begin
               state_nx_s = IDLE;
            end
         end
         SHIFT: begin
            if (shift_last_s) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = SHIFT;
            end
         end
         DONE: begin
            if (accept_s) begin
               state_nx_s = start_shift_s ? SHIFT : DONE;
            end else if (out_ready) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // State, shift datapath and registered result/flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         shift_op_r  <= 2'b00;
         work_r      <= '0;
         remaining_r <= '0;
         result_r    <= '0;
         cond_r      <= 1'b0;
         out_valid_r <= 1'b0;
`ifdef ALU_ILLEGAL_OP_EN
         illegal_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_nx_s;
         if (accept_s && start_shift_s) begin
            work_r      <= SrcA;
            remaining_r <= shamt_s;
            shift_op_r  <= Operation[1:0];
            out_valid_r <= 1'b0;
         end else if (accept_s) begin
            result_r    <= alu_result_s;
            cond_r      <= alu_cond_s;
            out_valid_r <= 1'b1;
`ifdef ALU_ILLEGAL_OP_EN
            illegal_r   <= alu_illegal_s;
`endif
         end else if (state_r == SHIFT) begin
            work_r      <= work_nx_s;
            remaining_r <= remaining_nx_s;
            if (shift_last_s) begin
               result_r    <= work_nx_s;
               cond_r      <= 1'b0;
               out_valid_r <= 1'b1;
`ifdef ALU_ILLEGAL_OP_EN
               illegal_r   <= 1'b0;
`endif
            end
         end else if ((state_r == DONE) && out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_iterative_alu.sv
// Directed self-checking bench for iterative_alu (DATA_WIDTH=32, SHIFT_STEP=1).
module tb_iterative_alu;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    Operation = 4'b0000;
   logic [DW-1:0] SrcA = '0;
   logic [DW-1:0] SrcB = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] ALUResult;
   logic          Cond;
`ifdef ALU_ILLEGAL_OP_EN
   logic          IllegalOp;
`endif

   int errors = 0;
   int checks = 0;

   iterative_alu #(.DATA_WIDTH(DW), .SHIFT_STEP(1)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .Operation(Operation),
      .SrcA(SrcA),
      .SrcB(SrcB),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .ALUResult(ALUResult),
`ifdef ALU_ILLEGAL_OP_EN
      .Cond(Cond),
      .IllegalOp(IllegalOp)
`else
      .Cond(Cond)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one op, scramble inputs after accept, measure latency, check, then hand off.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_cond, input int exp_lat);
      int lat;
      @(negedge clk);
      Operation = op;
      SrcA      = a;
      SrcB      = b;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      #1 check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      SrcA      = ~a;
      SrcB      = ~b;
      Operation = 4'b1111;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ".result"}, ALUResult, exp_res);
      check({tag, ".cond"}, 32'(Cond), 32'(exp_cond));
`ifdef ALU_ILLEGAL_OP_EN
      check({tag, ".illegal"}, 32'(IllegalOp),
            32'(!(op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                             4'b0110, 4'b0111, 4'b1000, 4'b1010, 4'b1100})));
`endif
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, ".handoff_valid"}, 32'(out_valid), 32'd0);
      check({tag, ".hold_result"}, ALUResult, exp_res);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      logic seen;
      repeat (3) @(posedge clk);
      #1;
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.result", ALUResult, 32'h0000_0000);
      check("rst.cond", 32'(Cond), 32'd0);
      check("rst.in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      reset = 1'b1;

      run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
      run_op("sub",      4'b0011, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1);
      run_op("and",      4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1);
      run_op("or",       4'b0001, 32'hF000_0001, 32'h0000_0010, 32'hF000_0011, 1'b0, 1);
      run_op("sra_neg",  4'b0111, 32'h8000_0000, 32'hFFFF_FFE4, 32'hF800_0000, 1'b0, 5);
      run_op("sra_pos",  4'b0111, 32'h7000_0000, 32'h0000_0003, 32'h0E00_0000, 1'b0, 4);
      run_op("srl",      4'b0101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 5);
      run_op("sll_31",   4'b0110, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 32);
      run_op("sll_0",    4'b0110, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b0, 1);
      run_op("sll_0hi",  4'b0110, 32'hABCD_0000, 32'h0000_0020, 32'hABCD_0000, 1'b0, 1);
      run_op("eq_t",     4'b1000, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 1'b1, 1);
      run_op("eq_f",     4'b1000, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1);
      run_op("ne_f",     4'b1010, 32'h0000_0003, 32'h0000_0003, 32'h0000_0003, 1'b0, 1);
      run_op("ne_t",     4'b1010, 32'h0000_0003, 32'h0000_0004, 32'h0000_0004, 1'b1, 1);
      run_op("slt_t",    4'b1100, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b1, 1);
      run_op("ill_f",    4'b1111, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b0, 1);
      run_op("slt_f",    4'b1100, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1);
      run_op("ne_t2",    4'b1010, 32'h0000_0003, 32'h0000_0004, 32'h0000_0004, 1'b1, 1);
      run_op("ill_9",    4'b1001, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b0, 1);

      // Backpressure: result must hold while a competing op is presented.
      @(negedge clk);
      Operation = 4'b1010;
      SrcA      = 32'h0000_0001;
      SrcB      = 32'h0000_0002;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      Operation = 4'b0010;
      SrcA      = 32'h0000_0100;
      SrcB      = 32'h0000_0200;
      for (int k = 0; k < 3; k++) begin
         check("stall.valid", 32'(out_valid), 32'd1);
         check("stall.result", ALUResult, 32'h0000_0002);
         check("stall.cond", 32'(Cond), 32'd1);
         check("stall.in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      Operation = 4'b0100;
      SrcA      = 32'h0000_F0F0;
      SrcB      = 32'h0000_0FF0;
      out_ready = 1'b1;
      #1 check("b2b.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check("b2b.valid", 32'(out_valid), 32'd1);
      check("b2b.result", ALUResult, 32'h0000_FF00);
      check("b2b.cond", 32'(Cond), 32'd0);
      @(negedge clk);
      Operation = 4'b0110;
      SrcA      = 32'h0000_0001;
      SrcB      = 32'h0000_0002;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_shift.valid_drop", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("b2b_shift.mid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("b2b_shift.valid", 32'(out_valid), 32'd1);
      check("b2b_shift.result", ALUResult, 32'h0000_0004);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("b2b_shift.handoff", 32'(out_valid), 32'd0);

      // Reset in the middle of a long shift, after a result with Cond set.
      run_op("ne_pre", 4'b1010, 32'h0000_0003, 32'h0000_0004, 32'h0000_0004, 1'b1, 1);
      @(negedge clk);
      Operation = 4'b0101;
      SrcA      = 32'hFFFF_FFFF;
      SrcB      = 32'h0000_001F;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("midrst.shifting", 32'(out_valid), 32'd0);
      repeat (5) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("midrst.out_valid", 32'(out_valid), 32'd0);
      check("midrst.result", ALUResult, 32'h0000_0000);
      check("midrst.cond", 32'(Cond), 32'd0);
      check("midrst.in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         seen = seen | out_valid;
      end
      check("midrst.no_valid", 32'(seen), 32'd0);
      run_op("post_rst", 4'b0010, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
